pose_sequencer: RTL and testbench

POSE_SEQUENCER -- requirements
Module: pose_sequencer

---
 rtl/pose_pkg.sv | 87 ++++++++
 rtl/vsync_tick.sv | 22 ++
 rtl/pose_sequencer.sv | 130 +++++++++++++
 tb/tb_pose_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pose_pkg.sv
// rtl/pose_pkg.sv - shared types, pose codes and action helpers for the pose sequencer
package pose_pkg;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    IDLE  = 2'd1,
    ANIM  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    JAB    = 3'd1,
    PUNCH  = 3'd2,
    CROUCH = 3'd3,
    UPCUT  = 3'd4
  } action_t;

  // Title-screen select codes
  localparam logic [1:0] START_PLAY  = 2'b00;
  localparam logic [1:0] START_IMG_A = 2'b01;
  localparam logic [1:0] START_IMG_B = 2'b10;

  // Pose codes; each action occupies a contiguous run so the next pose is code+1
  localparam logic [3:0] POSE_IDLE     = 4'b0000;
  localparam logic [3:0] POSE_JAB_1    = 4'b0001;
  localparam logic [3:0] POSE_JAB_2    = 4'b0010;
  localparam logic [3:0] POSE_JAB_3    = 4'b0011;
  localparam logic [3:0] POSE_PUNCH_1  = 4'b0100;
  localparam logic [3:0] POSE_PUNCH_2  = 4'b0101;
  localparam logic [3:0] POSE_PUNCH_3  = 4'b0110;
  localparam logic [3:0] POSE_PUNCH_4  = 4'b0111;
  localparam logic [3:0] POSE_CROUCH_1 = 4'b1000;
  localparam logic [3:0] POSE_CROUCH_2 = 4'b1001;
  localparam logic [3:0] POSE_CROUCH_3 = 4'b1010;
  localparam logic [3:0] POSE_CROUCH_4 = 4'b1011;
  localparam logic [3:0] POSE_CROUCH_5 = 4'b1100;
  localparam logic [3:0] POSE_CROUCH_6 = 4'b1101;
  localparam logic [3:0] POSE_UPCUT_1  = 4'b1110;
  localparam logic [3:0] POSE_UPCUT_2  = 4'b1111;

  // First and last pose of each action sequence
  localparam logic [3:0] JAB_FIRST    = POSE_JAB_1;
  localparam logic [3:0] JAB_LAST     = POSE_JAB_3;
  localparam logic [3:0] PUNCH_FIRST  = POSE_PUNCH_1;
  localparam logic [3:0] PUNCH_LAST   = POSE_PUNCH_4;
  localparam logic [3:0] CROUCH_FIRST = POSE_CROUCH_1;
  localparam logic [3:0] CROUCH_LAST  = POSE_CROUCH_6;
  localparam logic [3:0] UPCUT_FIRST  = POSE_UPCUT_1;
  localparam logic [3:0] UPCUT_LAST   = POSE_UPCUT_2;

  // Same-cycle requests resolve upcut > punch > jab > crouch
  function automatic action_t pick_action(input logic upcut, input logic punch,
                                          input logic jab, input logic crouch);
    action_t a;
    if (upcut)       a = UPCUT;
    else if (punch)  a = PUNCH;
    else if (jab)    a = JAB;
    else if (crouch) a = CROUCH;
    else             a = NONE;
    return a;
  endfunction

  function automatic logic [3:0] first_pose(input action_t a);
    logic [3:0] p;
    case (a)
      JAB:     p = JAB_FIRST;
      PUNCH:   p = PUNCH_FIRST;
      CROUCH:  p = CROUCH_FIRST;
      UPCUT:   p = UPCUT_FIRST;
      default: p = POSE_IDLE;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] last_pose(input action_t a);
    logic [3:0] p;
    case (a)
      JAB:     p = JAB_LAST;
      PUNCH:   p = PUNCH_LAST;
      CROUCH:  p = CROUCH_LAST;
      UPCUT:   p = UPCUT_LAST;
      default: p = POSE_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vsync_tick.sv
// rtl/vsync_tick.sv - one-cycle frame tick on each rising edge of vertical sync
module vsync_tick (
  input  logic Clk,
  input  logic Reset_n,
  input  logic vs,
  output logic tick
);

  logic vs_prev;

  // History resets high so a vs already high at release does not count as an edge
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_prev <= 1'b1;
    end else begin
      vs_prev <= vs;
    end
  end

  assign tick = vs & ~vs_prev;

endmodule

// File: rtl/pose_sequencer.sv
// rtl/pose_sequencer.sv - title blink, action pose sequencing with one-deep pending slot
module pose_sequencer
  import pose_pkg::*;
#(
  parameter int HOLD_FRAMES  = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vs,
  input  logic       start_btn,
  input  logic       jab_req,
  input  logic       punch_req,
  input  logic       crouch_req,
  input  logic       upcut_req,
  input  logic       end_screen,
  output logic [3:0] enable,
  output logic [1:0] start,
  output logic       busy
);

  // Terminal counts; counters compare against these and restart instead of wrapping
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_FRAMES - 1);
  localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);

  state_t     state;
  action_t    cur_act;
  action_t    pend_act;
  action_t    req_act;
  action_t    next_pend;
  logic [3:0] hold_cnt;
  logic [5:0] blink_cnt;
  logic       tick;

  vsync_tick u_vsync_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .vs      (vs),
    .tick    (tick)
  );

  assign req_act = pick_action(upcut_req, punch_req, jab_req, crouch_req);

  // The slot keeps the first arrival; a request this very cycle fills an empty slot
  assign next_pend = (pend_act != NONE) ? pend_act : req_act;

  // Main state machine; all outputs are registered here
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= TITLE;
      start     <= START_IMG_A;
      enable    <= POSE_IDLE;
      busy      <= 1'b0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      cur_act   <= NONE;
      pend_act  <= NONE;
    end else if (end_screen) begin
      state     <= IDLE;
      start     <= START_PLAY;
      enable    <= POSE_IDLE;
      busy      <= 1'b0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      cur_act   <= NONE;
      pend_act  <= NONE;
    end else begin
      case (state)
        TITLE: begin
          if (start_btn) begin
            state     <= IDLE;
            start     <= START_PLAY;
            blink_cnt <= '0;
          end else if (tick) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              start     <= (start == START_IMG_A) ? START_IMG_B : START_IMG_A;
            end else begin
              blink_cnt <= blink_cnt + 6'd1;
            end
          end
        end

        IDLE: begin
          if (req_act != NONE) begin
            state    <= ANIM;
            cur_act  <= req_act;
            enable   <= first_pose(req_act);
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end

        ANIM: begin
          pend_act <= next_pend;
          if (tick) begin
            if (hold_cnt != HOLD_LAST) begin
              hold_cnt <= hold_cnt + 4'd1;
            end else begin
              hold_cnt <= '0;
              if (enable != last_pose(cur_act)) begin
                enable <= enable + 4'd1;
              end else if (next_pend != NONE) begin
                cur_act  <= next_pend;
                enable   <= first_pose(next_pend);
                pend_act <= NONE;
              end else begin
                state   <= IDLE;
                cur_act <= NONE;
                enable  <= POSE_IDLE;
                busy    <= 1'b0;
              end
            end
          end
        end

        default: begin
          state    <= IDLE;
          start    <= START_PLAY;
          enable   <= POSE_IDLE;
          busy     <= 1'b0;
          hold_cnt <= '0;
          cur_act  <= NONE;
          pend_act <= NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pose_sequencer.sv
// tb/tb_pose_sequencer.sv - self-checking bench for pose_sequencer
module tb_pose_sequencer;

  localparam int HOLD  = 4;
  localparam int BLINK = 2;

  localparam bit [3:0] R_JAB    = 4'b0001;
  localparam bit [3:0] R_CROUCH = 4'b0010;
  localparam bit [3:0] R_PUNCH  = 4'b0100;
  localparam bit [3:0] R_UPCUT  = 4'b1000;

  logic       Clk;
  logic       Reset_n;
  logic       vs;
  logic       start_btn;
  logic       jab_req;
  logic       punch_req;
  logic       crouch_req;
  logic       upcut_req;
  logic       end_screen;
  logic [3:0] enable;
  logic [1:0] start;
  logic       busy;

  int checks;
  int failures;

  pose_sequencer #(
    .HOLD_FRAMES  (HOLD),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .vs         (vs),
    .start_btn  (start_btn),
    .jab_req    (jab_req),
    .punch_req  (punch_req),
    .crouch_req (crouch_req),
    .upcut_req  (upcut_req),
    .end_screen (end_screen),
    .enable     (enable),
    .start      (start),
    .busy       (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: game mode, title tick count, and a script holding one pose per remaining tick
  bit         m_title;
  int         m_ticks;
  bit         m_vs_prev;
  int         m_pend;
  logic [3:0] m_script[$];

  function automatic void m_reset();
    m_title   = 1'b1;
    m_ticks   = 0;
    m_vs_prev = 1'b1;
    m_pend    = 0;
    m_script.delete();
  endfunction

  function automatic int m_prio(input bit [3:0] r);
    if (r[3]) return 4;
    if (r[2]) return 2;
    if (r[0]) return 1;
    if (r[1]) return 3;
    return 0;
  endfunction

  function automatic void m_load(input int a);
    logic [3:0] codes[$];
    case (a)
      1: codes = '{4'd1, 4'd2, 4'd3};
      2: codes = '{4'd4, 4'd5, 4'd6, 4'd7};
      3: codes = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
      4: codes = '{4'd14, 4'd15};
      default: codes = {};
    endcase
    foreach (codes[i]) begin
      for (int k = 0; k < HOLD; k++) m_script.push_back(codes[i]);
    end
  endfunction

  function automatic void m_step(input bit v, input bit [3:0] r, input bit sb, input bit es);
    bit t;
    int a;
    t = v && !m_vs_prev;
    m_vs_prev = v;
    a = m_prio(r);
    if (es) begin
      m_title = 1'b0;
      m_pend  = 0;
      m_script.delete();
    end else if (m_title) begin
      if (sb) m_title = 1'b0;
      else if (t) m_ticks++;
    end else if (m_script.size() == 0) begin
      if (a != 0) m_load(a);
    end else begin
      if (m_pend == 0) m_pend = a;
      if (t) begin
        void'(m_script.pop_front());
        if (m_script.size() == 0 && m_pend != 0) begin
          m_load(m_pend);
          m_pend = 0;
        end
      end
    end
  endfunction

  function automatic logic [3:0] m_enable();
    return (m_script.size() != 0) ? m_script[0] : 4'd0;
  endfunction

  function automatic logic m_busy();
    return m_script.size() != 0;
  endfunction

  function automatic logic [1:0] m_start();
    if (!m_title) return 2'b00;
    return (((m_ticks / BLINK) % 2) == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic cyc(input bit v, input bit [3:0] r, input bit sb, input bit es);
    vs         = v;
    jab_req    = r[0];
    crouch_req = r[1];
    punch_req  = r[2];
    upcut_req  = r[3];
    start_btn  = sb;
    end_screen = es;
    @(posedge Clk);
    m_step(v, r, sb, es);
    #1;
  endtask

  task automatic pulse(input bit es);
    cyc(1'b0, 4'b0, 1'b0, es);
    cyc(1'b1, 4'b0, 1'b0, es);
    cyc(1'b0, 4'b0, 1'b0, es);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    vs = 1'b0; start_btn = 1'b0; end_screen = 1'b0;
    jab_req = 1'b0; punch_req = 1'b0; crouch_req = 1'b0; upcut_req = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (start !== 2'b01) begin failures++; $display("FAIL reset_start got=%b exp=01", start); end
    checks++;
    if (enable !== 4'b0000) begin failures++; $display("FAIL reset_enable got=%b exp=0000", enable); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    #1;
    Reset_n = 1'b1;
    m_reset();
    cyc(1'b0, 4'b0, 1'b0, 1'b0);
  endtask

  task automatic test_title_blink();
    logic [1:0] exp_seq[3];
    exp_seq = '{2'b01, 2'b10, 2'b10};
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0);
      checks++;
      if (start !== exp_seq[i] || enable !== 4'b0000) begin
        failures++;
        $display("FAIL title_blink_%0d got start=%b enable=%b exp start=%b enable=0000", i, start, enable, exp_seq[i]);
      end
    end
    cyc(1'b0, R_JAB, 1'b0, 1'b0);
    checks++;
    if (enable !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL title_ignores_req got enable=%b busy=%b exp 0000/0", enable, busy);
    end
    cyc(1'b0, 4'b0, 1'b1, 1'b0);
    checks++;
    if (start !== 2'b00 || enable !== 4'b0000) begin
      failures++; $display("FAIL title_exit got start=%b enable=%b exp 00/0000", start, enable);
    end
  endtask

  task automatic test_jab();
    int busy_ticks;
    logic [3:0] exp;
    busy_ticks = 0;
    cyc(1'b0, R_JAB, 1'b0, 1'b0);
    checks++;
    if (enable !== 4'b0001 || busy !== 1'b1) begin
      failures++; $display("FAIL jab_accept got enable=%b busy=%b exp 0001/1", enable, busy);
    end
    for (int k = 1; k <= 13; k++) begin
      if (busy === 1'b1) busy_ticks++;
      pulse(1'b0);
      exp = (k < 12) ? 4'(1 + k / HOLD) : 4'd0;
      checks++;
      if (enable !== exp || busy !== (k < 12)) begin
        failures++;
        $display("FAIL jab_tick_%0d got enable=%b busy=%b exp enable=%b busy=%0d", k, enable, busy, exp, (k < 12));
      end
    end
    checks++;
    if (busy_ticks != 12) begin failures++; $display("FAIL jab_busy_ticks got=%0d exp=12", busy_ticks); end
  endtask

  task automatic test_priority();
    bit crouch_seen;
    int n;
    crouch_seen = 1'b0;
    cyc(1'b0, R_UPCUT | R_CROUCH, 1'b0, 1'b0);
    checks++;
    if (enable !== 4'b1110) begin failures++; $display("FAIL prio_first got=%b exp=1110", enable); end
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      pulse(1'b0);
      if (enable >= 4'd8 && enable <= 4'd13) crouch_seen = 1'b1;
      n++;
    end
    checks++;
    if (crouch_seen || busy !== 1'b0 || n != 2 * HOLD) begin
      failures++;
      $display("FAIL prio_no_crouch got crouch_seen=%0d busy=%b ticks=%0d exp 0/0/%0d", crouch_seen, busy, n, 2 * HOLD);
    end
  endtask

  task automatic test_pending();
    bit crouch_seen;
    bit gap_checked;
    logic [3:0] prev;
    int n;
    crouch_seen = 1'b0;
    gap_checked = 1'b0;
    cyc(1'b0, R_PUNCH, 1'b0, 1'b0);
    repeat (HOLD) pulse(1'b0);
    checks++;
    if (enable !== 4'b0101) begin failures++; $display("FAIL pend_setup got=%b exp=0101", enable); end
    cyc(1'b0, R_JAB, 1'b0, 1'b0);
    cyc(1'b0, R_CROUCH, 1'b0, 1'b0);
    n = 0;
    prev = enable;
    while (busy === 1'b1 && n < 60) begin
      pulse(1'b0);
      if (enable >= 4'd8 && enable <= 4'd13) crouch_seen = 1'b1;
      if (prev == 4'b0111 && enable != 4'b0111) begin
        gap_checked = 1'b1;
        checks++;
        if (enable !== 4'b0001) begin failures++; $display("FAIL pend_chain got=%b exp=0001", enable); end
      end
      prev = enable;
      n++;
    end
    checks++;
    if (!gap_checked || crouch_seen || busy !== 1'b0) begin
      failures++;
      $display("FAIL pend_result got chained=%0d crouch_seen=%0d busy=%b exp 1/0/0", gap_checked, crouch_seen, busy);
    end
  endtask

  task automatic test_end_screen();
    int n;
    int nonzero;
    cyc(1'b0, R_CROUCH, 1'b0, 1'b0);
    n = 0;
    while (enable !== 4'b1011 && n < 30) begin pulse(1'b0); n++; end
    checks++;
    if (enable !== 4'b1011) begin failures++; $display("FAIL end_setup got=%b exp=1011", enable); end
    cyc(1'b0, R_JAB, 1'b0, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL end_force got enable=%b busy=%b exp 0000/0", enable, busy);
    end
    cyc(1'b0, R_PUNCH, 1'b0, 1'b1);
    pulse(1'b1);
    checks++;
    if (enable !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL end_ignore_punch got enable=%b busy=%b exp 0000/0", enable, busy);
    end
    nonzero = 0;
    for (int i = 0; i < 4; i++) begin
      pulse(1'b0);
      if (enable !== 4'b0000 || busy !== 1'b0) nonzero++;
    end
    checks++;
    if (nonzero != 0) begin failures++; $display("FAIL end_no_replay got active_ticks=%0d exp=0", nonzero); end
  endtask

  task automatic test_reset_mid();
    int active;
    cyc(1'b0, R_PUNCH, 1'b0, 1'b0);
    repeat (2 * HOLD) pulse(1'b0);
    checks++;
    if (enable !== 4'b0110) begin failures++; $display("FAIL rst_mid_setup got=%b exp=0110", enable); end
    cyc(1'b0, R_JAB, 1'b0, 1'b0);
    Reset_n = 1'b0;
    #1;
    checks++;
    if (start !== 2'b01 || enable !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_mid_async got start=%b enable=%b busy=%b exp 01/0000/0", start, enable, busy);
    end
    #1;
    Reset_n = 1'b1;
    m_reset();
    cyc(1'b0, 4'b0, 1'b1, 1'b0);
    active = 0;
    for (int i = 0; i < 20; i++) begin
      pulse(1'b0);
      if (enable !== 4'b0000 || busy !== 1'b0) active++;
    end
    checks++;
    if (active != 0) begin failures++; $display("FAIL rst_mid_no_replay got active_ticks=%0d exp=0", active); end
  endtask

  task automatic test_random();
    int vcnt;
    int vper;
    int es_left;
    bit v;
    bit sb;
    bit [3:0] r;
    do_reset();
    vcnt = 0;
    vper = 6;
    es_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 1499) == 0) do_reset();
      vcnt++;
      if (vcnt >= vper) begin vcnt = 0; vper = $urandom_range(3, 9); end
      v = (vcnt < 2);
      r = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      sb = ($urandom_range(0, 59) == 0);
      if (es_left > 0) es_left--;
      else if ($urandom_range(0, 299) == 0) es_left = $urandom_range(1, 6);
      cyc(v, r, sb, es_left > 0);
      checks++;
      if (enable !== m_enable() || start !== m_start() || busy !== m_busy()) begin
        failures++;
        $display("FAIL random_cycle_%0d got enable=%b start=%b busy=%b exp enable=%b start=%b busy=%b",
                 c, enable, start, busy, m_enable(), m_start(), m_busy());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    m_reset();
    test_reset();
    test_title_blink();
    test_jab();
    test_priority();
    test_pending();
    test_end_screen();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
